// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster constants, lock-state encoding and window helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  localparam int H_TOTAL_640 = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;  // 800
  localparam int V_TOTAL_480 = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;  // 525
  localparam int H_START_640 = H_SYNC_640 + H_BP_640;                            // 144
  localparam int V_START_480 = V_SYNC_480 + V_BP_480;                            // 35

  // Both position counters share one width and saturate at all-ones.
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  // True when cnt lies in [start, start+len).
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int start, input int len);
    return (int'(cnt) >= start) && (int'(cnt) < start + len);
  endfunction

endpackage

// File: rtl/vga_sync_receiver_checker.sv
// Sync edge detector with saturating period counter and length compare.
// Latency: edge/len_bad are combinational on stb; counter updates on the stb clock.
// Backpressure: none; state holds whenever stb is low.
//
// Ports: clk, reset (async, active-high); stb sampling strobe; sync_asserted
// sync input already normalised to 1 = asserted; edge_det asserted-edge seen
// on this strobe; len_bad edge whose period (cnt+1) differs from TOTAL;
// cnt_nxt counter value after this clock (0 on an edge).
module sync_period_checker
  import vga_timing::*;
#(
  parameter int TOTAL = 800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stb,
  input  logic             sync_asserted,
  output logic             edge_det,
  output logic             len_bad,
  output logic [CNT_W-1:0] cnt_nxt
);

  // prev_q resets to "asserted" so a source caught mid-sync cannot fake an
  // edge. In the vertical instance this register is the per-line vsync
  // sample (vs_line).
  logic             prev_q;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    edge_det = stb && sync_asserted && !prev_q;
    len_bad  = edge_det && ((int'(cnt) + 1) != TOTAL);
    cnt_nxt  = cnt;
    if (stb) begin
      if (edge_det) begin
        cnt_nxt = '0;
      end else if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
      cnt    <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (stb) begin
        prev_q <= sync_asserted;
      end
    end
  end

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers x/y from hsync/vsync edges, tracks lock, counts errors/frames.
// Latency: all outputs registered, valid one clk after the pix_en sample that caused them.
// Backpressure: none; nothing moves without pix_en, all state holds while it is low.
//
// Ports: clk, reset (async, active-high); pix_en pixel strobe; hsync/vsync
// sync pair (asserted level SYNC_POL); rx_x/rx_y active coordinates (0 outside
// window); rx_active locked and in window; locked; err one-clk violation pulse;
// err_count saturating at 255; frame_count wrapping 16-bit.
module vga_sync_receiver
  import vga_timing::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_640,
  parameter int   H_FP     = H_FP_640,
  parameter int   H_SYNC   = H_SYNC_640,
  parameter int   H_BP     = H_BP_640,
  parameter int   V_ACTIVE = V_ACTIVE_480,
  parameter int   V_FP     = V_FP_480,
  parameter int   V_SYNC   = V_SYNC_480,
  parameter int   V_BP     = V_BP_480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hsync,
  input  logic             vsync,
  output logic [CNT_W-1:0] rx_x,
  output logic [CNT_W-1:0] rx_y,
  output logic             rx_active,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);

  rx_state_t        state;
  logic             hs_asserted, vs_asserted;
  logic             h_edge, h_bad, vref, v_bad;
  logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt;
  logic             x_win, y_win, fault, lock_nxt;

  assign hs_asserted = (hsync == SYNC_POL);
  assign vs_asserted = (vsync == SYNC_POL);

  sync_period_checker #(.TOTAL(H_TOTAL)) u_h_chk (
    .clk           (clk),
    .reset         (reset),
    .stb           (pix_en),
    .sync_asserted (hs_asserted),
    .edge_det      (h_edge),
    .len_bad       (h_bad),
    .cnt_nxt       (hcnt_nxt)
  );

  // vsync is only looked at on line starts, so hsync/vsync skew within a
  // line cannot move the vertical reference.
  sync_period_checker #(.TOTAL(V_TOTAL)) u_v_chk (
    .clk           (clk),
    .reset         (reset),
    .stb           (h_edge),
    .sync_asserted (vs_asserted),
    .edge_det      (vref),
    .len_bad       (v_bad),
    .cnt_nxt       (vcnt_nxt)
  );

  // Windows decode the post-sample counters so the coordinates describe the
  // pixel just strobed, not the one before it.
  always_comb begin
    x_win    = in_window(hcnt_nxt, H_START, H_ACTIVE);
    y_win    = in_window(vcnt_nxt, V_START, V_ACTIVE);
    fault    = h_bad || v_bad;
    lock_nxt = ((state == LOCKED) && !fault) ||
               ((state == ACQUIRE) && vref && !h_bad && !v_bad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_active   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (pix_en) begin
        rx_x      <= x_win ? (hcnt_nxt - H_START_C) : '0;
        rx_y      <= y_win ? (vcnt_nxt - V_START_C) : '0;
        rx_active <= x_win && y_win && lock_nxt;
        locked    <= lock_nxt;
        case (state)
          SEARCH: begin
            if (vref) state <= ACQUIRE;
          end
          ACQUIRE: begin
            // A bad frame length leaves us in ACQUIRE: this reference simply
            // restarts the frame measurement.
            if (h_bad) begin
              state <= SEARCH;
            end else if (vref && !v_bad) begin
              state <= LOCKED;
            end
          end
          LOCKED: begin
            // Line and frame faults on the same edge are one error, and a
            // fault always wins over the frame count on that edge.
            if (fault) begin
              err   <= 1'b1;
              state <= SEARCH;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (vref) begin
              frame_count <= frame_count + 16'd1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
module tb_vga_sync_receiver;

  // Small raster keeps every scenario short: 8 px/line, 5 lines/frame.
  localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_ACTIVE = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL = 8, V_TOTAL = 5;

  logic        clk = 1'b0;
  logic        reset, pix_en, hsync, vsync;
  logic [9:0]  rx_x, rx_y;
  logic        rx_active, locked, err;
  logic [7:0]  err_count;
  logic [15:0] frame_count;

  int n_chk = 0, n_pass = 0;
  int gh = 0, gv = 0, lh = 0, lv = 0;
  int cur_line_len = H_TOTAL, cur_frame_len = V_TOTAL, pix_gap = 2;

  vga_sync_receiver #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active), .locked(locked),
    .err(err), .err_count(err_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One pixel strobe from the reference generator; returns right after the
  // clock edge that sampled it, so registered outputs describe pixel (lv,lh).
  task automatic strobe();
    repeat (pix_gap) @(negedge clk);
    @(negedge clk);
    hsync  = (gh < H_SYNC) ? 1'b0 : 1'b1;
    vsync  = (gv < V_SYNC) ? 1'b0 : 1'b1;
    pix_en = 1'b1;
    lh = gh;
    lv = gv;
    @(negedge clk);
    pix_en = 1'b0;
    gh++;
    if (gh >= cur_line_len) begin
      gh = 0;
      cur_line_len = H_TOTAL;
      gv++;
      if (gv >= cur_frame_len) begin
        gv = 0;
        cur_frame_len = V_TOTAL;
      end
    end
  endtask

  task automatic run_until(input int v, input int h);
    int   n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 400) begin
      strobe();
      n++;
      hit = (lv == v) && (lh == h);
    end
    check($sformatf("reach_%0d_%0d", v, h), hit, 1'b1);
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_rx_x", rx_x, 0);
    check("rst_rx_y", rx_y, 0);
    check("rst_rx_active", rx_active, 0);

    // Nominal lock: first vref at strobe 40, lock on the strobe at 80.
    repeat (2 * H_TOTAL * V_TOTAL) strobe();
    check("prelock_locked", locked, 0);
    strobe();
    check("lock_locked", locked, 1);
    check("lock_frame_count", frame_count, 0);

    // Coordinates: first active pixel, last active pixel, front porch.
    run_until(2, 3);
    check("first_px_x", rx_x, 0);
    check("first_px_y", rx_y, 0);
    check("first_px_active", rx_active, 1);
    run_until(3, 6);
    check("last_px_x", rx_x, 3);
    check("last_px_y", rx_y, 1);
    check("last_px_active", rx_active, 1);
    run_until(3, 7);
    check("hfp_active", rx_active, 0);
    check("hfp_x", rx_x, 0);
    run_until(4, 3);
    check("vfp_y", rx_y, 0);
    check("vfp_active", rx_active, 0);
    run_until(0, 0);
    check("frame1_count", frame_count, 1);

    // Short line while locked.
    run_until(1, 0);
    cur_line_len = H_TOTAL - 1;
    run_until(2, 0);
    check("short_err", err, 1);
    check("short_err_count", err_count, 1);
    check("short_locked", locked, 0);
    check("short_frame_count", frame_count, 1);
    strobe();
    check("short_err_pulse", err, 0);
    run_until(0, 0);
    check("relock_vref1", locked, 0);
    run_until(0, 0);
    check("relock_vref2", locked, 1);

    // Long frame while locked.
    cur_frame_len = V_TOTAL + 1;
    run_until(0, 0);
    check("long_err", err, 1);
    check("long_err_count", err_count, 2);
    check("long_locked", locked, 0);
    check("long_frame_count", frame_count, 1);

    // Long frame during ACQUIRE: silent.
    run_until(0, 0);
    cur_frame_len = V_TOTAL + 1;
    run_until(0, 0);
    check("acq_long_err", err, 0);
    check("acq_long_err_count", err_count, 2);
    check("acq_long_locked", locked, 0);
    run_until(0, 0);
    run_until(0, 0);
    check("acq_relock", locked, 1);

    // Reset mid-frame inside the active window.
    run_until(3, 5);
    check("prerst_active", rx_active, 1);
    check("prerst_x", rx_x, 2);
    check("prerst_y", rx_y, 1);
    reset = 1'b1;
    #1;
    check("midrst_locked", locked, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_x", rx_x, 0);
    check("midrst_y", rx_y, 0);
    check("midrst_active", rx_active, 0);
    @(negedge clk);
    reset = 1'b0;
    run_until(0, 0);
    check("postrst_vref1", locked, 0);
    run_until(0, 0);
    check("postrst_vref2", locked, 1);

    // Stall: no strobes for 1000 clks while the sync lines wiggle.
    run_until(2, 4);
    check("prestall_x", rx_x, 1);
    repeat (1000) begin
      @(negedge clk);
      hsync = ~hsync;
      vsync = $urandom_range(1, 0) == 1;
    end
    check("stall_x", rx_x, 1);
    check("stall_y", rx_y, 0);
    check("stall_active", rx_active, 1);
    check("stall_locked", locked, 1);
    check("stall_frame_count", frame_count, 0);
    strobe();
    check("unstall_x", rx_x, 2);
    check("unstall_locked", locked, 1);

    // frame_count wrap.
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    check("preload_frame_count", frame_count, 16'hFFFF);
    run_until(0, 0);
    check("wrap_frame_count", frame_count, 0);
    check("wrap_locked", locked, 1);

    // 300 locked errors: err_count saturates at 255.
    pix_gap = 0;
    for (int i = 0; i < 300; i++) begin
      cur_line_len = H_TOTAL - 1;
      run_until(1, 0);
      if (i == 0) check("sat_first_count", err_count, 1);
      if (i == 254) check("sat_255_count", err_count, 255);
      run_until(0, 0);
      run_until(0, 0);
    end
    check("sat_final_count", err_count, 255);
    check("sat_final_locked", locked, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Timing receiver for the 640x480 VGA raster. It consumes the hSync/vSync pair that display_controller drives and recovers pixel coordinates from the sync edges alone. It checks every line and frame length against the nominal timing and reports lock, errors and frame count. It sits beside display_controller as an in-system timing monitor and as the bench-side checker for any sync generator in the design.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- pix_en  in  1  one-clk pixel strobe (every 4th clk); all sampling happens only on pix_en
- hsync  in  1  horizontal sync from generator
- vsync  in  1  vertical sync from generator
- rx_x  out  10  recovered active column 0..639; 0 outside active window
- rx_y  out  10  recovered active row 0..479; 0 outside active window
- rx_active  out  1  locked and inside active window
- locked  out  1  timing lock established
- err  out  1  one-clk pulse on a timing violation while locked
- err_count  out  8  violations while locked, saturates at 255
- frame_count  out  16  vertical references seen while locked, wraps at 65535->0

Decisions: one clock; reset is asynchronous and active-high.

## Operation
- H_TOTAL = 800 and V_TOTAL = 525 are derived from the parameters.
- H edge: hsync is sampled asserted on pix_en and was deasserted at the previous pix_en.
- hcnt: 10-bit, cleared to 0 on the H edge, otherwise increments on pix_en and saturates at 1023.
- At each H edge:
  - line length = hcnt+1 is checked against H_TOTAL.
  - vsync is sampled into vs_line.
  - vcnt increments, saturating at 1023.
- Vertical reference (vref): vs_line is asserted at this H edge and was deasserted at the previous H edge. This makes detection immune to hsync/vsync skew within a line.
- At vref:
  - frame length = vcnt+1 is checked against V_TOTAL.
  - vcnt is cleared to 0.
- X window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), giving rx_x = hcnt-144.
- Y window: vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE), giving rx_y = vcnt-35.
- State machine SEARCH / ACQUIRE / LOCKED:
  - SEARCH: length checks are ignored. On the first vref, go to ACQUIRE.
  - ACQUIRE: a bad line length returns to SEARCH, with no err and no count. A vref with a good frame length goes to LOCKED.
  - LOCKED: a bad line or frame length pulses err, increments err_count and returns to SEARCH. Each good vref increments frame_count.
- Simultaneous bad line and bad frame on the same edge count as one error.
- A line error takes precedence over the vref transition on the same edge.

## Timing
- Reset values:
  - state = SEARCH; hcnt = vcnt = 0.
  - Previous hsync and previous vs_line samples = asserted, so a generator caught mid-sync cannot produce a false edge.
  - All outputs = 0.
- All outputs are registered, one clk after the pix_en sample that caused them.
- rx_x/rx_y/rx_active update only on pix_en and hold between strobes.
- No pix_en means all state holds indefinitely.
- Reset asserted mid-frame clears everything immediately. Lock then requires a full SEARCH→ACQUIRE→LOCKED sequence again.
- The earliest lock from reset is two vrefs, i.e. at the start of the second complete frame seen.

## Structure
- A shared package/include vga_timing holds:
  - the 640x480 constants and the derived H_TOTAL/V_TOTAL/H_START=144/V_START=35;
  - the state encodings SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
- Sub-module sync_period_checker (edge detect, saturating counter, length compare) is instantiated twice:
  - horizontal instance: strobe = pix_en, input = hsync;
  - vertical instance: strobe = H edge, input = vs_line.
- The top holds the FSM, the window decode and the counters.

## Test plan
- Nominal: reset, then run display_controller timing from hcnt=vcnt=0 → locked rises 1 clk after pixel strobe 840000. At 0.
- Coordinates: while locked, sample at line 35 pixel 144 → rx_x=0, rx_y=0, rx_active=1.
- Coordinates: at line 514 pixel 783 → rx_x=639, rx_y=479. At pixel 784 → rx_active=0.
- Short line: one line of 799 pixels while locked → single err pulse, err_count=1, locked=0, frame_count holds. Relock after two clean vrefs.
- Long frame: 526 lines while locked → err pulse, SEARCH. The same fault during ACQUIRE → no err and err_count unchanged.
- Reset mid-frame: assert reset at line 200 pixel 400 → all outputs 0 immediately. After release no lock until two vrefs.
- Stall and wrap:
  - Gate pix_en off for 1000 clks → outputs frozen.
  - Preload frame_count=65535, then one good vref → 0.
  - 300 locked errors → err_count=255.
